p4_pipe_addsub: RTL and testbench



---
 rtl/p4_pipe_addsub_if.sv | 39 +++
 rtl/p4_pipe_addsub.sv | 144 ++++++++++++++
 tb/tb_p4_pipe_addsub.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p4_pipe_addsub_if.sv
// p4_pipe_addsub_if
// Handshake and data bundle for the pipelined P4 adder/subtractor.
//   master : operand source / result consumer side (drives operands, out_ready)
//   slave  : the adder pipeline (drives in_ready and the result fields)
// Signals:
//   in_valid/in_ready   operand transfer handshake
//   a, b, cin, sub      operands, carry-in and add(0)/subtract(1) select
//   in_tag              user tag travelling with the operation
//   out_valid/out_ready result transfer handshake
//   s, cout, ovf        result, MSB carry-out, two's-complement overflow
//   out_tag             tag belonging to the presented result
interface p4_pipe_addsub_if #(
    parameter int NBIT  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [NBIT-1:0]  a;
    logic [NBIT-1:0]  b;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [NBIT-1:0]  s;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, a, b, cin, sub, in_tag, out_ready,
        input  in_ready, out_valid, s, cout, ovf, out_tag
    );

    modport slave (
        input  in_valid, a, b, cin, sub, in_tag, out_ready,
        output in_ready, out_valid, s, cout, ovf, out_tag
    );
endinterface

// File: rtl/p4_pipe_addsub.sv
// p4_pipe_addsub
// Pipelined add/subtract unit. The NBIT operation is cut into NSTAGES equal
// slices; stage k adds slice k-1 with a carry-select adder built from
// NBIT_PER_BLOCK-bit blocks, and the slice carry is registered for the next
// stage. Operands ride forward with the operation (skew) and finished low
// slices ride forward too (deskew) so the result leaves bit-aligned.
// A single global enable stalls every stage when the output is held.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset, drops everything in flight
//   bus  : p4_pipe_addsub_if slave modport (handshakes, operands, result)
module p4_pipe_addsub #(
    parameter int NBIT           = 32,
    parameter int NBIT_PER_BLOCK = 4,
    parameter int NSTAGES        = 2,
    parameter int TAG_W          = 4
) (
    input logic               clk,
    input logic               rst,
    p4_pipe_addsub_if.slave   bus
);
    localparam int SW   = NBIT / NSTAGES;
    localparam int NBLK = SW / NBIT_PER_BLOCK;
    localparam int LAST = NSTAGES - 1;
    localparam logic [NBIT_PER_BLOCK:0] ONE = 1;

    // Carry-select slice adder: every block precomputes its sum for both
    // incoming carries and the rippling block carry only picks one.
    function automatic logic [SW:0] slice_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci
    );
        logic [SW-1:0]           sum;
        logic                    c;
        logic [NBIT_PER_BLOCK:0] r0;
        logic [NBIT_PER_BLOCK:0] r1;
        sum = '0;
        c   = ci;
        for (int k = 0; k < NBLK; k++) begin
            r0 = {1'b0, x[k*NBIT_PER_BLOCK +: NBIT_PER_BLOCK]}
               + {1'b0, y[k*NBIT_PER_BLOCK +: NBIT_PER_BLOCK]};
            r1 = r0 + ONE;
            sum[k*NBIT_PER_BLOCK +: NBIT_PER_BLOCK] =
                c ? r1[NBIT_PER_BLOCK-1:0] : r0[NBIT_PER_BLOCK-1:0];
            c = c ? r1[NBIT_PER_BLOCK] : r0[NBIT_PER_BLOCK];
        end
        return {c, sum};
    endfunction

    // Stage inputs (element i feeds stage i+1)
    logic [NBIT-1:0]  a_in   [NSTAGES];
    logic [NBIT-1:0]  b_in   [NSTAGES];
    logic [NBIT-1:0]  s_in   [NSTAGES];
    logic             c_in   [NSTAGES];
    logic             v_in   [NSTAGES];
    logic [TAG_W-1:0] t_in   [NSTAGES];

    // Stage registers (element i is the output of stage i+1)
    logic [NBIT-1:0]  a_q    [NSTAGES];
    logic [NBIT-1:0]  b_q    [NSTAGES];
    logic [NBIT-1:0]  s_q    [NSTAGES];
    logic             c_q    [NSTAGES];
    logic             v_q    [NSTAGES];
    logic [TAG_W-1:0] t_q    [NSTAGES];

    logic [SW:0]      slice_res [NSTAGES];
    logic [NBIT-1:0]  s_next    [NSTAGES];
    logic             ovf_next;
    logic             ovf_q;
    logic             en;

    // The pipeline only moves when the output register is empty or being
    // drained; in_ready must not depend on in_valid.
    assign en           = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = v_q[LAST];
    assign bus.s         = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.out_tag   = t_q[LAST];

    // Stage 1 takes the bus with B already conditioned for subtraction
    // (invert B, fold the sub into the carry-in); later stages take the
    // previous stage's registers. Each stage drops its slice into the
    // partially built result word.
    always_comb begin
        for (int i = 0; i < NSTAGES; i++) begin
            if (i == 0) begin
                a_in[i] = bus.a;
                b_in[i] = bus.b ^ {NBIT{bus.sub}};
                s_in[i] = '0;
                c_in[i] = bus.cin ^ bus.sub;
                v_in[i] = bus.in_valid;
                t_in[i] = bus.in_tag;
            end else begin
                a_in[i] = a_q[i-1];
                b_in[i] = b_q[i-1];
                s_in[i] = s_q[i-1];
                c_in[i] = c_q[i-1];
                v_in[i] = v_q[i-1];
                t_in[i] = t_q[i-1];
            end
            slice_res[i] = slice_add(a_in[i][i*SW +: SW], b_in[i][i*SW +: SW], c_in[i]);
            s_next[i]    = s_in[i];
            s_next[i][i*SW +: SW] = slice_res[i][SW-1:0];
        end
        // Overflow: operands agree in sign but the result sign differs.
        ovf_next = (a_in[LAST][NBIT-1] == b_in[LAST][NBIT-1])
                && (s_next[LAST][NBIT-1] != a_in[LAST][NBIT-1]);
    end

    // Valid bits advance on every enabled cycle so bubbles travel as
    // valid=0; data registers only load behind a valid operation so the
    // last delivered result stays on s/cout/ovf/out_tag across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
                v_q[i] <= 1'b0;
                t_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < NSTAGES; i++) begin
                v_q[i] <= v_in[i];
                if (v_in[i]) begin
                    a_q[i] <= a_in[i];
                    b_q[i] <= b_in[i];
                    s_q[i] <= s_next[i];
                    c_q[i] <= slice_res[i][SW];
                    t_q[i] <= t_in[i];
                end
            end
            if (v_in[LAST]) begin
                ovf_q <= ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_p4_pipe_addsub.sv
// tb_p4_pipe_addsub
// Directed bench for p4_pipe_addsub (NBIT=32, NSTAGES=2). A reference
// model computes each result from plain wide arithmetic; a monitor queues
// the expected result on every accepted input and compares on every
// delivered output, also checking latency and hold-stability under stall.
module tb_p4_pipe_addsub;
    localparam int NBIT    = 32;
    localparam int NSTAGES = 2;
    localparam int TAG_W   = 4;

    logic clk;
    logic rst;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_out  = 0;
    bit lat_check = 1'b1;

    logic [37:0] exp_q[$];
    int          acc_q[$];
    bit          held_valid = 1'b0;
    logic [37:0] held;

    p4_pipe_addsub_if #(.NBIT(NBIT), .TAG_W(TAG_W)) bus ();

    p4_pipe_addsub #(
        .NBIT(NBIT),
        .NBIT_PER_BLOCK(4),
        .NSTAGES(NSTAGES),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Reference result {s, cout, ovf, tag} from the arithmetic rules.
    function automatic logic [37:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub,
                                          input logic [3:0] mtag);
        logic [31:0] bp;
        logic [32:0] full;
        logic        v;
        bp   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bp} + {32'd0, mcin ^ msub};
        v    = (ma[31] == bp[31]) && (full[31] != ma[31]);
        return {full[31:0], full[32], v, mtag};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: no response within bound (t=%0t)", name, $time);
    endtask

    // Offer one operation and hold it until accepted; returns 1 time unit
    // after the accepting edge with in_valid dropped.
    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic icin, input logic isub, input logic [3:0] itag);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = ia;
        bus.b = ib;
        bus.cin = icin;
        bus.sub = isub;
        bus.in_tag = itag;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) failNote("input_accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // One isolated operation with hand-computed result and latency.
    task automatic singleOp(input string name, input logic [31:0] ia, input logic [31:0] ib,
                            input logic icin, input logic isub, input logic [3:0] itag,
                            input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        applyStimulus(ia, ib, icin, isub, itag);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            failNote({name, "_timeout"});
        end else begin
            checkOutput({name, "_latency"}, lat, NSTAGES);
            checkOutput({name, "_s"}, bus.s, es);
            checkOutput({name, "_cout"}, bus.cout, ec);
            checkOutput({name, "_ovf"}, bus.ovf, eo);
            checkOutput({name, "_tag"}, bus.out_tag, itag);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: push on input transfer, compare on output
    // transfer, and require a stalled result to stay put.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                checkOutput("hold_valid", bus.out_valid, 1'b1);
                checkOutput("hold_result", {bus.s, bus.cout, bus.ovf, bus.out_tag}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL spurious_output: got tag 0x%0h expected no result (t=%0t)",
                             bus.out_tag, $time);
                end else begin
                    logic [37:0] e;
                    int          a0;
                    e  = exp_q.pop_front();
                    a0 = acc_q.pop_front();
                    checkOutput("result", {bus.s, bus.cout, bus.ovf, bus.out_tag}, e);
                    if (lat_check) checkOutput("stream_latency", cyc - a0, NSTAGES);
                    n_out++;
                end
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held       = {bus.s, bus.cout, bus.ovf, bus.out_tag};
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.in_tag));
                acc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] bp_a [4] = '{32'h89AB_CDEF, 32'h0000_0010, 32'h7FFF_0000, 32'h1234_5678};
    logic [31:0] bp_b [4] = '{32'h7654_3211, 32'h0000_0020, 32'h0001_0000, 32'h1234_5678};
    logic        bp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit          in_pat [3] = '{1'b1, 1'b0, 1'b1};
    logic        rec [8];

    initial begin
        int n0;
        bit got;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0000_0001;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.in_tag = 4'hA;
        bus.out_ready = 1'b1;

        // Pin the reference model against hand-computed values.
        checkOutput("model_carry", model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3),
                    {32'h0000_0000, 1'b1, 1'b0, 4'd3});
        checkOutput("model_ovf", model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd1),
                    {32'h8000_0000, 1'b0, 1'b1, 4'd1});
        checkOutput("model_sub_neg", model(32'd5, 32'd7, 1'b0, 1'b1, 4'd2),
                    {32'hFFFF_FFFE, 1'b0, 1'b0, 4'd2});
        checkOutput("model_sub_pos", model(32'd7, 32'd5, 1'b0, 1'b1, 4'd4),
                    {32'h0000_0002, 1'b1, 1'b0, 4'd4});

        // Reset held two cycles with an operand offered.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_out_valid", bus.out_valid, 1'b0);
            checkOutput("rst_s", bus.s, 32'h0);
            checkOutput("rst_cout", bus.cout, 1'b0);
            checkOutput("rst_ovf", bus.ovf, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_release_in_ready", bus.in_ready, 1'b1);
        checkOutput("rst_release_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] directed single operations");
        singleOp("carry_boundary", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3,
                 32'h0000_0000, 1'b1, 1'b0);
        singleOp("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd1,
                 32'h8000_0000, 1'b0, 1'b1);
        singleOp("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 4'd2,
                 32'hFFFF_FFFE, 1'b0, 1'b0);
        singleOp("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 4'd4,
                 32'h0000_0002, 1'b1, 1'b0);
        singleOp("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd6,
                 32'h7FFF_FFFF, 1'b1, 1'b1);
        singleOp("cin_cross", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 4'd7,
                 32'h0001_0001, 1'b0, 1'b0);

        $display("[TB] backpressure stream");
        lat_check = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int t = 0; t < 4; t++)
                    applyStimulus(bp_a[t], bp_b[t], 1'b0, bp_s[t], 4'(t + 1));
            end
            begin
                got = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    @(posedge clk);
                    #2;
                    if (bus.out_valid) begin
                        bus.out_ready = 1'b0;
                        got = 1'b1;
                        break;
                    end
                end
                if (!got) begin
                    failNote("bp_first_valid");
                end else begin
                    checkOutput("bp_first_tag", bus.out_tag, 4'd1);
                    repeat (3) begin
                        @(negedge clk);
                        checkOutput("bp_stall_in_ready", bus.in_ready, 1'b0);
                        @(posedge clk);
                        #2;
                    end
                end
                bus.out_ready = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp_delivered", n_out - n0, 4);
        lat_check = 1'b1;

        $display("[TB] bubble pattern");
        fork
            begin
                applyStimulus(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 4'd8);
                @(posedge clk);
                #1;
                applyStimulus(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 4'd9);
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    rec[k] = bus.out_valid;
                end
            end
        join
        for (int k = 0; k < 8; k++) begin
            logic e;
            e = (k >= NSTAGES && k - NSTAGES < 3) ? in_pat[k - NSTAGES] : 1'b0;
            checkOutput("bubble_out_valid", rec[k], e);
        end
        @(posedge clk);
        #1;

        $display("[TB] reset mid-flight");
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 4'd9);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 32'h0000_0003;
        bus.b = 32'h0000_0004;
        bus.in_tag = 4'd10;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("rst_flight_no_valid", bus.out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        singleOp("after_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 4'd5,
                 32'h0000_0030, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
